// File: rtl/axi4lite_uart_fifo_regs_pkg.sv
// uart_regs_pkg: shared definitions for the AXI4-Lite UART FIFO register bank.
//   - reg_idx_e : register index decoded from address bits [3:2]
//   - STATUS and CTRL bit positions
package uart_regs_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } reg_idx_e;

    // STATUS register layout
    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_FULL    = 2;
    localparam int unsigned ST_RX_EMPTY   = 3;
    localparam int unsigned ST_TX_OVF     = 4;
    localparam int unsigned ST_RX_UDF     = 5;
    localparam int unsigned ST_RX_CNT_LSB = 8;
    localparam int unsigned ST_TX_CNT_LSB = 16;
    localparam int unsigned ST_CNT_W      = 8;

    // CTRL register layout
    localparam int unsigned CTRL_IRQ_RX_EN  = 0;
    localparam int unsigned CTRL_IRQ_TX_EN  = 1;
    localparam int unsigned CTRL_IRQ_ERR_EN = 2;
    localparam int unsigned CTRL_W          = 3;

endpackage

// File: rtl/axi4lite_uart_fifo_regs_if.sv
// axi4lite_uart_fifo_regs_if: register-access side of the UART register bank,
// as supplied by the AXI4-Lite protocol decoder.
//   wr_amba/addr_wc/data_in/strb : write strobe, address, data, byte strobes
//   rd_amba/addr_rc/data_out     : read strobe, address, combinational read data
// Modports: master (decoder side), slave (register bank side).
interface axi4lite_uart_fifo_regs_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic                  wr_amba;
    logic                  rd_amba;
    logic [31:0]           addr_wc;
    logic [31:0]           addr_rc;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   strb;
    logic [DATA_W-1:0]     data_out;

    modport master (
        output wr_amba, rd_amba, addr_wc, addr_rc, data_in, strb,
        input  data_out
    );

    modport slave (
        input  wr_amba, rd_amba, addr_wc, addr_rc, data_in, strb,
        output data_out
    );
endinterface

// File: rtl/axi4lite_uart_fifo_regs_sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two.
//   push/wdata : write request; accepted if not full, or full with a pop
//   pop        : read request; ignored while empty
//   rdata      : head entry, forced to 0 while empty
//   full/empty : registered-state decodes of count
//   count      : occupancy, 0..DEPTH
// Storage is not reset; pointers and count reset asynchronously (rst low).
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    // A pop on an empty FIFO is a no-op even when a push lands in the same
    // cycle; a push on a full FIFO only lands if a real pop frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/axi4lite_uart_fifo_regs.sv
// axi4lite_uart_fifo_regs: AXI4-Lite register bank between the bus decoder and
// the UART serialiser/deserialiser, with TX and RX FIFOs.
//   clk, rst        : clock; asynchronous active-low reset
//   bus (slave)     : register access (see axi4lite_uart_fifo_regs_if)
//   tx_data/txValid/txReady : TX stream out of the TX FIFO
//   rx_data/rxValid/rxReady : RX stream into the RX FIFO
//   irq             : level interrupt
// Register map (addr[3:2]): 0 TXDATA (WO), 1 RXDATA (RO, read pops),
//   2 STATUS (sticky bits W1C), 3 CTRL.
// Build option UART_REG_IRQ_EN: implements CTRL and a registered irq; when
// undefined, CTRL reads 0, ignores writes and irq is tied low.
module axi4lite_uart_fifo_regs
    import uart_regs_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    axi4lite_uart_fifo_regs_if.slave     bus,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         txValid,
    input  logic                         txReady,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         rxValid,
    output logic                         rxReady,
    output logic                         irq
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    reg_idx_e          wr_idx;
    reg_idx_e          rd_idx;
    logic              byte0_wr;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     rx_count;
    logic [DATA_W-1:0] rx_head;
    logic              st_wr;
    logic              tx_ovf;
    logic              rx_udf;
    logic              tx_ovf_set;
    logic              rx_udf_set;
    logic [31:0]       status_w;
    logic [CTRL_W-1:0] ctrl_q;
    logic              unused_addr_bits;

    assign wr_idx   = reg_idx_e'(bus.addr_wc[3:2]);
    assign rd_idx   = reg_idx_e'(bus.addr_rc[3:2]);
    // Byte 0 is written when its strobe is set or when no strobe is set at all.
    assign byte0_wr = (bus.strb == '0) || bus.strb[0];

    assign tx_push  = bus.wr_amba && (wr_idx == REG_TXDATA);
    assign tx_pop   = txValid && txReady;
    assign rx_push  = rxValid && rxReady;
    assign rx_pop   = bus.rd_amba && (rd_idx == REG_RXDATA);

    assign txValid  = !tx_empty;
    assign rxReady  = !rx_full;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus.data_in),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Error flags: a new error in the same cycle as a W1C clear wins.
    assign st_wr      = bus.wr_amba && (wr_idx == REG_STATUS) && byte0_wr;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_udf_set = rx_pop && rx_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set || (tx_ovf && !(st_wr && bus.data_in[ST_TX_OVF]));
            rx_udf <= rx_udf_set || (rx_udf && !(st_wr && bus.data_in[ST_RX_UDF]));
        end
    end

`ifdef UART_REG_IRQ_EN
    logic ctrl_wr;
    logic irq_q;

    assign ctrl_wr = bus.wr_amba && (wr_idx == REG_CTRL) && byte0_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_q <= bus.data_in[CTRL_W-1:0];
            irq_q <= (ctrl_q[CTRL_IRQ_RX_EN]  && !rx_empty)
                  || (ctrl_q[CTRL_IRQ_TX_EN]  && tx_empty)
                  || (ctrl_q[CTRL_IRQ_ERR_EN] && (tx_ovf || rx_udf));
        end
    end

    assign irq = irq_q;
`else
    assign ctrl_q = '0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        status_w                                 = '0;
        status_w[ST_TX_FULL]                     = tx_full;
        status_w[ST_TX_EMPTY]                    = tx_empty;
        status_w[ST_RX_FULL]                     = rx_full;
        status_w[ST_RX_EMPTY]                    = rx_empty;
        status_w[ST_TX_OVF]                      = tx_ovf;
        status_w[ST_RX_UDF]                      = rx_udf;
        status_w[ST_RX_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(rx_count);
        status_w[ST_TX_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(tx_count);
    end

    always_comb begin
        bus.data_out = '0;
        case (rd_idx)
            REG_RXDATA: bus.data_out = rx_head;
            REG_STATUS: bus.data_out = DATA_W'(status_w);
            REG_CTRL:   bus.data_out = DATA_W'(ctrl_q);
            default:    bus.data_out = '0;
        endcase
    end

    assign unused_addr_bits = ^{bus.addr_wc[31:4], bus.addr_wc[1:0],
                                bus.addr_rc[31:4], bus.addr_rc[1:0]};

endmodule

// File: tb/tb_axi4lite_uart_fifo_regs.sv
// Directed self-checking bench for axi4lite_uart_fifo_regs (DATA_W=32,
// FIFO_DEPTH=4). Build with or without UART_REG_IRQ_EN.
module tb_axi4lite_uart_fifo_regs;

    localparam logic [31:0] A_TX = 32'h0, A_RX = 32'h4, A_ST = 32'h8, A_CT = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tx_data;
    logic        txValid;
    logic        txReady = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rxValid = 1'b0;
    logic        rxReady;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    axi4lite_uart_fifo_regs_if #(.DATA_W(32)) bus ();

    axi4lite_uart_fifo_regs #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx_data (tx_data),
        .txValid (txValid),
        .txReady (txReady),
        .rx_data (rx_data),
        .rxValid (rxValid),
        .rxReady (rxReady),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.wr_amba = 1'b1;
        bus.addr_wc = a;
        bus.data_in = d;
        bus.strb    = s;
        tick();
        bus.wr_amba = 1'b0;
        bus.data_in = '0;
        bus.strb    = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.rd_amba = 1'b1;
        bus.addr_rc = a;
        #1;
        d = bus.data_out;
        tick();
        bus.rd_amba = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.addr_rc = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h0000_000A); end
        n_checks++;
        if (rxReady !== 1'b1) begin n_fail++; $display("FAIL reset_rxReady: got %b expected 1", rxReady); end
        n_checks++;
        if (txValid !== 1'b0) begin n_fail++; $display("FAIL reset_txValid: got %b expected 0", txValid); end
        n_checks++;
        if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        peek(A_CT, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        txReady = 1'b0;
        bus_write(A_TX, 32'h11, 4'h0);
        n_checks++;
        if (txValid !== 1'b1 || tx_data !== 32'h11) begin
            n_fail++; $display("FAIL tx_first_latency: got valid=%b data=%h expected valid=1 data=00000011", txValid, tx_data);
        end
        for (int i = 2; i <= 5; i++) bus_write(A_TX, 32'h11 * i, 4'h0);
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0004_0019) begin n_fail++; $display("FAIL tx_full_status: got %h expected %h", d, 32'h0004_0019); end
        txReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (txValid !== 1'b1 || tx_data !== 32'h11 * i) begin
                n_fail++; $display("FAIL tx_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, txValid, tx_data, 32'h11 * i);
            end
            tick();
        end
        txReady = 1'b0;
        n_checks++;
        if (txValid !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++; $display("FAIL tx_drained: got valid=%b data=%h expected valid=0 data=0", txValid, tx_data);
        end
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_001A) begin n_fail++; $display("FAIL tx_ovf_sticky: got %h expected %h", d, 32'h0000_001A); end
        bus_write(A_ST, 32'h30, 4'h0);
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL tx_ovf_clear: got %h expected %h", d, 32'h0000_000A); end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rxReady !== 1'b1) begin n_fail++; $display("FAIL rx_ready_before_push_%0d: got %b expected 1", i, rxReady); end
            rxValid = 1'b1;
            rx_data = 32'hA5 + 32'h11 * i;
            tick();
        end
        rxValid = 1'b0;
        n_checks++;
        if (rxReady !== 1'b0) begin n_fail++; $display("FAIL rx_ready_full: got %b expected 0", rxReady); end
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_0406) begin n_fail++; $display("FAIL rx_full_status: got %h expected %h", d, 32'h0000_0406); end
        bus_read(A_RX, d);
        n_checks++;
        if (d !== 32'hA5) begin n_fail++; $display("FAIL rx_read_0: got %h expected %h", d, 32'hA5); end
        n_checks++;
        if (rxReady !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after_pop: got %b expected 1", rxReady); end
        for (int i = 1; i < 4; i++) begin
            bus_read(A_RX, d);
            n_checks++;
            if (d !== 32'hA5 + 32'h11 * i) begin n_fail++; $display("FAIL rx_read_%0d: got %h expected %h", i, d, 32'hA5 + 32'h11 * i); end
        end
        bus_read(A_RX, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rx_underflow_data: got %h expected 0", d); end
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_002A) begin n_fail++; $display("FAIL rx_udf_status: got %h expected %h", d, 32'h0000_002A); end
        bus_write(A_ST, 32'h30, 4'h0);
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL rx_udf_clear: got %h expected %h", d, 32'h0000_000A); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        txReady = 1'b0;
        for (int i = 1; i <= 4; i++) bus_write(A_TX, i, 4'h0);
        txReady = 1'b1;
        bus_write(A_TX, 32'h5, 4'h0);
        txReady = 1'b0;
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0004_0009) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected %h", d, 32'h0004_0009); end
        txReady = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if (tx_data !== i) begin n_fail++; $display("FAIL full_pushpop_order_%0d: got %h expected %h", i, tx_data, i); end
            tick();
        end
        txReady = 1'b0;
        n_checks++;
        if (txValid !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_empty: got %b expected 0", txValid); end
    endtask

    task automatic test_sticky_race();
        logic [31:0] d;
        for (int i = 1; i <= 5; i++) bus_write(A_TX, 32'h60 + i, 4'h0);
        bus_write(A_ST, 32'h30, 4'b0010);
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0004_0019) begin n_fail++; $display("FAIL w1c_byte1_only: got %h expected %h", d, 32'h0004_0019); end
        // W1C of both flags coincident with a new RX underflow
        bus.wr_amba = 1'b1;
        bus.addr_wc = A_ST;
        bus.data_in = 32'h30;
        bus.strb    = 4'b0001;
        bus.rd_amba = 1'b1;
        bus.addr_rc = A_RX;
        tick();
        bus.wr_amba = 1'b0;
        bus.rd_amba = 1'b0;
        bus.strb    = '0;
        bus.data_in = '0;
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0004_0029) begin n_fail++; $display("FAIL set_wins_over_clear: got %h expected %h", d, 32'h0004_0029); end
        bus_write(A_ST, 32'h30, 4'h0);
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0004_0009) begin n_fail++; $display("FAIL sticky_clear_full: got %h expected %h", d, 32'h0004_0009); end
        n_checks++;
        if (tx_data !== 32'h61) begin n_fail++; $display("FAIL race_tx_head: got %h expected %h", tx_data, 32'h61); end
        txReady = 1'b1;
        repeat (4) tick();
        txReady = 1'b0;
    endtask

    task automatic test_misc_access();
        logic [31:0] d;
        bus_write(A_RX, 32'hDEAD_BEEF, 4'h0);
        peek(A_ST, d);
        n_checks++;
        if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL rxdata_write_ignored: got %h expected %h", d, 32'h0000_000A); end
        bus_write(A_TX, 32'h77, 4'b0001);
        n_checks++;
        if (tx_data !== 32'h77) begin n_fail++; $display("FAIL txdata_ignores_strb: got %h expected %h", tx_data, 32'h77); end
        bus_read(A_TX, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_reads_zero: got %h expected 0", d); end
        txReady = 1'b1;
        tick();
        txReady = 1'b0;
    endtask

    task automatic test_reset_midop();
        bus_write(A_TX, 32'h99, 4'h0);
        rxValid = 1'b1;
        rx_data = 32'h42;
        tick();
        rxValid = 1'b0;
        rst = 1'b0;
        #2;
        n_checks++;
        if (txValid !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++; $display("FAIL midop_reset_tx: got valid=%b data=%h expected valid=0 data=0", txValid, tx_data);
        end
        bus.addr_rc = A_ST;
        #1;
        n_checks++;
        if (bus.data_out !== 32'h0000_000A) begin n_fail++; $display("FAIL midop_reset_status: got %h expected %h", bus.data_out, 32'h0000_000A); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ctrl_irq();
        logic [31:0] d;
        logic [31:0] exp_ct;
        logic        exp_irq;
        bus_write(A_CT, 32'hFF, 4'h0);
        peek(A_CT, d);
`ifdef UART_REG_IRQ_EN
        exp_ct = 32'h7;
`else
        exp_ct = 32'h0;
`endif
        n_checks++;
        if (d !== exp_ct) begin n_fail++; $display("FAIL ctrl_write: got %h expected %h", d, exp_ct); end
        bus_write(A_CT, 32'h1, 4'b0001);
        bus_write(A_CT, 32'h7, 4'b0010);
        peek(A_CT, d);
`ifdef UART_REG_IRQ_EN
        exp_ct = 32'h1;
        exp_irq = 1'b1;
`else
        exp_ct = 32'h0;
        exp_irq = 1'b0;
`endif
        n_checks++;
        if (d !== exp_ct) begin n_fail++; $display("FAIL ctrl_strobe: got %h expected %h", d, exp_ct); end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq); end
        rxValid = 1'b1;
        rx_data = 32'h3C;
        tick();
        rxValid = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency_1: got %b expected 0", irq); end
        tick();
        n_checks++;
        if (irq !== exp_irq) begin n_fail++; $display("FAIL irq_latency_2: got %b expected %b", irq, exp_irq); end
        bus_read(A_RX, d);
        n_checks++;
        if (d !== 32'h3C) begin n_fail++; $display("FAIL irq_rx_read: got %h expected %h", d, 32'h3C); end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq); end
        bus_write(A_CT, 32'h0, 4'h0);
    endtask

    initial begin
        bus.wr_amba = 1'b0;
        bus.rd_amba = 1'b0;
        bus.addr_wc = '0;
        bus.addr_rc = '0;
        bus.data_in = '0;
        bus.strb    = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_tx_overflow();
        test_rx();
        test_full_push_pop();
        test_sticky_race();
        test_misc_access();
        test_reset_midop();
        test_ctrl_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
